mipi_rx_raw_depacker: RTL and testbench

//  Multi-format MIPI CSI-2 pixel depacker. Parametrised successor to the fixed RAW10 depacker.

---
 rtl/mipi_rx_raw_depacker_pkg.sv | 43 ++++
 rtl/mipi_rx_raw_depacker_if.sv | 30 +++
 rtl/mipi_rx_raw_depacker_unpack.sv | 46 ++++
 rtl/mipi_rx_raw_depacker.sv | 123 ++++++++++++
 tb/tb_mipi_rx_raw_depacker.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mipi_rx_raw_depacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mipi_rx_pkg
// Brief    : Shared mode encodings and helpers for the CSI-2 RAW depacker.
//            The macro MIPI_DEPACK_RAW12_EN enables RAW12 support.
// Revision : 1.0 - initial release
// ============================================================================
package mipi_rx_pkg;

    localparam logic [1:0] RAW_MODE_8  = 2'd0;
    localparam logic [1:0] RAW_MODE_10 = 2'd1;
    localparam logic [1:0] RAW_MODE_12 = 2'd2;

`ifdef MIPI_DEPACK_RAW12_EN
    localparam int unsigned MAX_GROUP_BYTES = 6;
`else
    localparam int unsigned MAX_GROUP_BYTES = 5;
`endif

    // Bytes carrying four pixels in the given mode.
    function automatic int unsigned group_bytes(input logic [1:0] mode);
        case (mode)
            RAW_MODE_8:  return 4;
            RAW_MODE_10: return 5;
            default:     return 6;
        endcase
    endfunction

    function automatic logic mode_supported(input logic [1:0] mode);
`ifdef MIPI_DEPACK_RAW12_EN
        return (mode != 2'd3);
`else
        return (mode == RAW_MODE_8) || (mode == RAW_MODE_10);
`endif
    endfunction

    // Left-justify a src_w-bit sample inside a 12-bit field.
    function automatic logic [11:0] msb_align(input logic [11:0] val, input int unsigned src_w);
        return val << (12 - src_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_rx_raw_depacker_if.sv
`default_nettype none
// ============================================================================
// Module   : mipi_rx_raw_depacker_if
// Brief    : Payload-in / pixels-out bundle of the RAW depacker.
// Revision : 1.0 - initial release
// ============================================================================
interface mipi_rx_raw_depacker_if #(
    parameter int IN_BYTES = 4,
    parameter int PIX_W    = 12
);
    logic                            line_valid_i;
    logic                            data_valid_i;
    logic [IN_BYTES*8-1:0]           data_i;
    logic [1:0]                      mode_i;
    logic                            output_valid_o;
    logic [(IN_BYTES/4)*4*PIX_W-1:0] output_o;
    logic                            leftover_o;
    logic                            mode_err_o;

    modport master (
        output line_valid_i, data_valid_i, data_i, mode_i,
        input  output_valid_o, output_o, leftover_o, mode_err_o
    );

    modport slave (
        input  line_valid_i, data_valid_i, data_i, mode_i,
        output output_valid_o, output_o, leftover_o, mode_err_o
    );
endinterface
`default_nettype wire

// File: rtl/mipi_rx_raw_depacker_unpack.sv
`default_nettype none
// ============================================================================
// Module   : raw_group_unpack
// Brief    : Combinational unpack of one byte group into four MSB-aligned
//            pixels. RAW12 decode present only with MIPI_DEPACK_RAW12_EN.
// Revision : 1.0 - initial release
// ============================================================================
module raw_group_unpack
    import mipi_rx_pkg::*;
#(
    parameter int PIX_W = 12
) (
    input  wire logic [8*MAX_GROUP_BYTES-1:0] i_bytes,
    input  wire logic [1:0]                   i_mode,
    output logic      [4*PIX_W-1:0]           o_pixels
);

    logic [7:0]  w_b  [MAX_GROUP_BYTES];
    logic [11:0] w_al [4];

    for (genvar j = 0; j < MAX_GROUP_BYTES; j++) begin : g_byte
        assign w_b[j] = i_bytes[8*j +: 8];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_al[i] = msb_align({4'd0, w_b[i]}, 8);
            if (i_mode == RAW_MODE_10) begin
                w_al[i] = msb_align({2'd0, w_b[i], w_b[4][2*i +: 2]}, 10);
            end
`ifdef MIPI_DEPACK_RAW12_EN
            // Byte 2 carries the nibbles of pixels 0/1, byte 5 those of 2/3.
            if (i_mode == RAW_MODE_12) begin
                w_al[i] = msb_align({w_b[(i < 2) ? i : i + 1],
                                     w_b[(i < 2) ? 2 : 5][4*(i%2) +: 4]}, 12);
            end
`endif
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_pix
        assign o_pixels[k*PIX_W +: PIX_W] = PIX_W'({w_al[k], 20'd0} >> (32 - PIX_W));
    end

endmodule
`default_nettype wire

// File: rtl/mipi_rx_raw_depacker.sv
`default_nettype none
// ============================================================================
// Module   : mipi_rx_raw_depacker
// Brief    : CSI-2 RAW8/10/12 depacker: byte accumulator, per-line mode latch
//            and line-end drain. RAW12 enabled by MIPI_DEPACK_RAW12_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mipi_rx_raw_depacker
    import mipi_rx_pkg::*;
#(
    parameter int IN_BYTES = 4,
    parameter int PIX_W    = 12
) (
    input wire logic                 clk_i,
    input wire logic                 reset_i,
    mipi_rx_raw_depacker_if.slave    bus
);

    localparam int          c_groups   = IN_BYTES / 4;
    localparam int unsigned c_in_bytes = IN_BYTES;
    localparam int          c_cap      = IN_BYTES + c_groups * MAX_GROUP_BYTES - 1;
    localparam int          c_acc_w    = c_cap * 8;
    localparam int          c_cnt_w    = $clog2(c_cap + 1);
    localparam int          c_gb_w     = 8 * MAX_GROUP_BYTES;
    localparam int          c_out_w    = c_groups * 4 * PIX_W;

    logic               r_lv_d;
    logic               r_ok;
    logic [1:0]         r_mode;
    logic [c_cnt_w-1:0] r_count;
    logic [c_acc_w-1:0] r_acc;
    logic               r_out_valid;
    logic [c_out_w-1:0] r_out;
    logic               r_leftover;
    logic               r_mode_err;

    logic               w_rise;
    logic               w_line_ok;
    logic               w_append;
    logic               w_emit;
    logic               w_discard;
    int unsigned        w_gg;
    int unsigned        w_base_cnt;
    int unsigned        w_cons;
    int unsigned        w_remain;
    int unsigned        w_next_cnt;
    logic [c_acc_w-1:0] w_base_acc;
    logic [c_acc_w-1:0] w_next_acc;
    logic [c_out_w-1:0] w_pixels;
    logic [c_gb_w-1:0]  w_grp_bytes [c_groups];

    // Bytes at or above the count are kept zero, so appends can simply OR in.
    always_comb begin
        w_rise     = bus.line_valid_i && !r_lv_d;
        w_line_ok  = w_rise ? mode_supported(bus.mode_i) : r_ok;
        w_append   = bus.line_valid_i && bus.data_valid_i && w_line_ok;
        w_gg       = c_groups * group_bytes(r_mode);
        w_base_cnt = w_rise ? 0 : 32'(r_count);
        w_base_acc = w_rise ? '0 : r_acc;
        w_emit     = (w_base_cnt >= w_gg);
        w_cons     = w_emit ? w_gg : 0;
        w_remain   = w_base_cnt - w_cons;
        // A new line also flushes anything an unfinished drain left behind.
        w_discard  = (r_count != '0) && (w_rise || (!bus.line_valid_i && !w_emit));
        w_next_acc = w_base_acc >> (w_cons * 8);
        w_next_cnt = w_remain;
        if (w_append) begin
            w_next_acc = w_next_acc | (c_acc_w'(bus.data_i) << (w_remain * 8));
            w_next_cnt = w_remain + c_in_bytes;
        end
        if (w_discard && !w_rise) begin
            w_next_acc = '0;
            w_next_cnt = 0;
        end
    end

    for (genvar k = 0; k < c_groups; k++) begin : g_grp
        assign w_grp_bytes[k] = c_gb_w'(w_base_acc >> (k * group_bytes(r_mode) * 8));

        raw_group_unpack #(
            .PIX_W (PIX_W)
        ) u_unpack (
            .i_bytes  (w_grp_bytes[k]),
            .i_mode   (r_mode),
            .o_pixels (w_pixels[k*4*PIX_W +: 4*PIX_W])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lv_d      <= 1'b0;
            r_ok        <= 1'b0;
            r_mode      <= RAW_MODE_8;
            r_count     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_leftover  <= 1'b0;
            r_mode_err  <= 1'b0;
        end else begin
            r_lv_d <= bus.line_valid_i;
            if (w_rise) begin
                r_mode <= bus.mode_i;
                r_ok   <= mode_supported(bus.mode_i);
            end
            r_count     <= c_cnt_w'(w_next_cnt);
            r_acc       <= w_next_acc;
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out <= w_pixels;
            end
            r_leftover  <= w_discard;
            r_mode_err  <= w_rise && !mode_supported(bus.mode_i);
        end
    end

    assign bus.output_valid_o = r_out_valid;
    assign bus.output_o       = r_out;
    assign bus.leftover_o     = r_leftover;
    assign bus.mode_err_o     = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_mipi_rx_raw_depacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_rx_raw_depacker
// Brief    : Scoreboard bench: line-level byte model predicts beats and
//            leftover/mode-error pulses; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mipi_rx_raw_depacker;

    localparam int IN_BYTES = 4;
    localparam int PIX_W    = 12;
    localparam int GROUPS   = IN_BYTES / 4;
    localparam int OUT_W    = GROUPS * 4 * PIX_W;
    localparam int EVT_LEFT = 1;
    localparam int EVT_ERR  = 2;

    typedef logic [IN_BYTES*8-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [OUT_W-1:0] exp_beats [$];
    int               exp_evt   [$];
    logic [7:0]       line_bytes[$];
    word_t            line_words[$];

    mipi_rx_raw_depacker_if #(.IN_BYTES(IN_BYTES), .PIX_W(PIX_W)) bus ();

    mipi_rx_raw_depacker #(.IN_BYTES(IN_BYTES), .PIX_W(PIX_W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit ref_supported(input logic [1:0] m);
`ifdef MIPI_DEPACK_RAW12_EN
        return m != 2'd3;
`else
        return m < 2'd2;
`endif
    endfunction

    // Pixel i of the group starting at line byte 'base', left-justified to PIX_W.
    function automatic int ref_pixel(input int mode, input int base, input int i);
        int b[6];
        int val;
        int w;
        for (int j = 0; j < 6; j++)
            b[j] = (base + j < line_bytes.size()) ? int'(line_bytes[base + j]) : 0;
        if (mode == 0) begin
            val = b[i];
            w   = 8;
        end else if (mode == 1) begin
            val = b[i] * 4 + ((b[4] >> (2 * i)) % 4);
            w   = 10;
        end else begin
            case (i)
                0:       val = b[0] * 16 + (b[2] % 16);
                1:       val = b[1] * 16 + (b[2] / 16);
                2:       val = b[3] * 16 + (b[5] % 16);
                default: val = b[4] * 16 + (b[5] / 16);
            endcase
            w = 12;
        end
        return val << (PIX_W - w);
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.output_valid_o) begin
                if (exp_beats.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got pixels %h, expected no beat", bus.output_o);
                end else begin
                    check("beat", bus.output_o, exp_beats.pop_front());
                end
            end
            if (bus.leftover_o) begin
                if (exp_evt.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_leftover: got pulse, expected none");
                end else begin
                    check("leftover_event", OUT_W'(EVT_LEFT), OUT_W'(exp_evt.pop_front()));
                end
            end
            if (bus.mode_err_o) begin
                if (exp_evt.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_mode_err: got pulse, expected none");
                end else begin
                    check("mode_err_event", OUT_W'(EVT_ERR), OUT_W'(exp_evt.pop_front()));
                end
            end
        end
    end

    task automatic run_line(input logic [1:0] mode, input bit gaps, input bit chg_mode);
        int g;
        int gg;
        int nbeats;
        word_t wd;
        logic [OUT_W-1:0] vec;
        line_bytes.delete();
        foreach (line_words[n]) begin
            wd = line_words[n];
            for (int j = 0; j < IN_BYTES; j++) line_bytes.push_back(wd[j*8 +: 8]);
        end
        if (!ref_supported(mode)) begin
            exp_evt.push_back(EVT_ERR);
        end else begin
            g      = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 5 : 6;
            gg     = GROUPS * g;
            nbeats = line_bytes.size() / gg;
            for (int bt = 0; bt < nbeats; bt++) begin
                vec = '0;
                for (int k = 0; k < GROUPS; k++)
                    for (int i = 0; i < 4; i++)
                        vec[(k*4 + i)*PIX_W +: PIX_W] = PIX_W'(ref_pixel(int'(mode), bt*gg + k*g, i));
                exp_beats.push_back(vec);
            end
            if (line_bytes.size() % gg != 0) exp_evt.push_back(EVT_LEFT);
        end
        @(negedge clk);
        bus.line_valid_i = 1'b1;
        bus.mode_i       = mode;
        foreach (line_words[n]) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                bus.data_valid_i = 1'b0;
                bus.data_i       = word_t'($urandom);
                @(negedge clk);
            end
            bus.data_valid_i = 1'b1;
            bus.data_i       = line_words[n];
            @(negedge clk);
            if (chg_mode) bus.mode_i = 2'($urandom);
        end
        bus.line_valid_i = 1'b0;
        // Data strobes outside a line must be ignored.
        for (int c = 0; c < 8; c++) begin
            bus.data_valid_i = c[0];
            bus.data_i       = word_t'($urandom);
            @(negedge clk);
        end
        bus.data_valid_i = 1'b0;
        for (int c = 0; c < 20 && (exp_beats.size() != 0 || exp_evt.size() != 0); c++) @(negedge clk);
        check("line_drained", OUT_W'(exp_beats.size() + exp_evt.size()), '0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_flags"}, OUT_W'({bus.output_valid_o, bus.leftover_o, bus.mode_err_o}), '0);
        check({tag, "_pixels"}, bus.output_o, '0);
    endtask

    task automatic rand_words(input int n);
        line_words.delete();
        for (int i = 0; i < n; i++) line_words.push_back(word_t'($urandom));
    endtask

    initial begin
        bus.line_valid_i = 1'b0;
        bus.data_valid_i = 1'b0;
        bus.data_i       = '0;
        bus.mode_i       = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        line_words = '{32'h12345678, 32'h00BCDEF0};
        run_line(2'd1, 1'b0, 1'b0);
        line_words = '{32'h12345678};
        run_line(2'd0, 1'b0, 1'b0);
        line_words = '{32'h12345678, 32'hAAAA9ABC};
        run_line(2'd2, 1'b0, 1'b0);

        rand_words(15);
        run_line(2'd1, 1'b0, 1'b0);
        rand_words(3);
        run_line(2'd1, 1'b0, 1'b0);
        line_words = '{32'h12345678, 32'h00BCDEF0};
        run_line(2'd1, 1'b0, 1'b0);

        rand_words(6);
        run_line(2'd3, 1'b0, 1'b0);
        rand_words(10);
        run_line(2'd1, 1'b1, 1'b1);

        // Reset in the middle of a line with a partial group buffered.
        @(negedge clk);
        bus.line_valid_i = 1'b1;
        bus.mode_i       = 2'd1;
        bus.data_valid_i = 1'b1;
        bus.data_i       = word_t'($urandom);
        @(negedge clk);
        rst              = 1'b1;
        bus.line_valid_i = 1'b0;
        bus.data_valid_i = 1'b0;
        @(negedge clk);
        check_reset_state("mid_line_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        line_words = '{32'h12345678, 32'h00BCDEF0};
        run_line(2'd1, 1'b0, 1'b0);

        for (int l = 0; l < 30; l++) begin
            rand_words($urandom_range(1, 20));
            run_line(2'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
